// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl
//   Data-cache read-miss refill controller. On a miss it fetches the four
//   32-bit words of the 16-byte line from main memory, one word request at
//   a time. It assembles them into a 128-bit line and then issues a single
//   fill strobe into the cache data/tag/valid arrays.
//
//   Build option: define DCACHE_CRITICAL_WORD_FIRST_EN to begin the fetch at
//   the missing word (miss_addr[3:2]) and wrap around the line. Without it,
//   fetch order is always 0,1,2,3. Line placement is the same in both builds.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   miss_req    in   read miss (level), sampled only in IDLE
//   miss_addr   in   [31:0] byte address of the missing read
//   mem_req     out  word-read request to main memory
//   mem_addr    out  [31:0] word-aligned read address
//   mem_ack     in   mem_rdata valid this cycle
//   mem_rdata   in   [31:0] memory read data
//   fill_we     out  one-cycle cache fill strobe
//   fill_index  out  [INDEX_W-1:0] line index to fill
//   fill_tag    out  [TAG_W-1:0] tag to fill
//   fill_line   out  [127:0] line, word w at bits [32w+31:32w]
//   busy        out  high whenever not IDLE
module dcache_refill_ctrl #(
  parameter int TAG_W   = 24,
  parameter int INDEX_W = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic               fill_we,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [127:0]       fill_line,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [1:0]         word_q;   // line slot of the word currently requested
  logic [1:0]         count_q;  // words accepted so far in this refill
  logic [127:0]       line_q;
  logic [127:0]       line_merged;
  logic [1:0]         start_word;
  logic               start, accept, last;
  logic               unused_addr_bits;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  assign start_word       = miss_addr[3:2];
  assign unused_addr_bits = ^miss_addr[1:0];
`else
  assign start_word       = 2'd0;
  assign unused_addr_bits = ^miss_addr[3:0];
`endif

  always_comb begin
    state_next  = state;
    start       = 1'b0;
    accept      = 1'b0;
    last        = (count_q == 2'd3);
    line_merged = line_q;
    line_merged[{word_q, 5'd0} +: 32] = mem_rdata;
    case (state)
      IDLE:    if (miss_req) begin
                 start      = 1'b1;
                 state_next = FETCH;
               end
      FETCH:   if (mem_ack) begin
                 accept = 1'b1;
                 if (last) state_next = WRITE;
               end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are registered, so they are loaded one edge ahead of the state
  // they belong to. The final word is merged straight into fill_line, which
  // puts fill_we in the cycle right after the 4th ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q      <= '0;
      index_q    <= '0;
      word_q     <= '0;
      count_q    <= '0;
      line_q     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_we    <= 1'b0;
      fill_index <= '0;
      fill_tag   <= '0;
      fill_line  <= '0;
      busy       <= 1'b0;
    end else begin
      fill_we <= 1'b0;
      if (start) begin
        tag_q    <= miss_addr[31 -: TAG_W];
        index_q  <= miss_addr[4 +: INDEX_W];
        word_q   <= start_word;
        count_q  <= '0;
        mem_req  <= 1'b1;
        mem_addr <= {miss_addr[31 -: TAG_W], miss_addr[4 +: INDEX_W], start_word, 2'b00};
        busy     <= 1'b1;
      end
      if (accept) begin
        line_q  <= line_merged;
        word_q  <= word_q + 2'd1;
        count_q <= count_q + 2'd1;
        if (last) begin
          mem_req    <= 1'b0;
          fill_we    <= 1'b1;
          fill_line  <= line_merged;
          fill_tag   <= tag_q;
          fill_index <= index_q;
        end else begin
          mem_addr <= {tag_q, index_q, word_q + 2'd1, 2'b00};
        end
      end
      if (state == WRITE) busy <= 1'b0;
    end
  end

endmodule
